// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared definitions for the pipeline stall controller:
//                HI/LO sequencer state encoding, the "operand unused" Tuse
//                code and default mult/div busy latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    // HI/LO multiply/divide sequencer states
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Tuse value meaning "this operand is never read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default busy latencies and countdown width
    localparam int DEF_MULT_CYC = 5;
    localparam int DEF_DIV_CYC  = 10;
    localparam int DEF_CNT_W    = 4;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_md_busy_cnt
//  Description : HI/LO multiply/divide busy sequencer. A start accepted at a
//                clock edge keeps o_busy high for exactly MULT_CYC or DIV_CYC
//                cycles after that edge.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                i_start  - mult/div issues from E this cycle
//                i_div    - with i_start: 1 = div/divu, 0 = mult/multu
//                i_squash - flush in progress; a coincident start is dropped
//                o_busy   - unit busy (sequencer in BUSY)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl_md_busy_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_div,
    input  logic i_squash,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                // A start flushed by an exception never reaches the unit
                if (i_start && !i_squash) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = i_div ? C_DIV_LOAD : C_MULT_LOAD;
                end
            end
            MD_BUSY: begin
                // Already committed: exceptions do not stop the countdown,
                // and a start here is ignored (D-stage stall prevents it).
                if (r_cnt == C_ONE) begin
                    w_state_nxt = MD_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule : pipe_stall_ctrl_md_busy_cnt
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Pipeline sequencing controller for the 5-stage MIPS core.
//                Each cycle the D register and PC either advance, hold with a
//                bubble into E, or the whole pipe is flushed on exc_req.
//  Ports       : clk, reset (async active-low)
//                D_rs/D_rt, D_tuse_rs/D_tuse_rt  - D-stage operand info
//                E_wa/E_tnew, M_wa/M_tnew        - in-flight producers
//                D_is_md, E_md_start, E_md_div   - HI/LO sequencing
//                D_is_eret, E_mtc0_epc, M_mtc0_epc - eret vs. EPC write
//                exc_req                         - CP0 flush request
//                Req, D_REG_Wr, PC_Wr, E_REG_clr, md_busy - controls
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic       E_md_div,
    input  logic       D_is_eret,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    input  logic       exc_req,
    output logic       Req,
    output logic       D_REG_Wr,
    output logic       PC_Wr,
    output logic       E_REG_clr,
    output logic       md_busy
);

    logic w_rs_used;
    logic w_rt_used;
    logic w_rs_hazard;
    logic w_rt_hazard;
    logic w_md_stall;
    logic w_epc_stall;
    logic w_stall;

    // An unused operand (Tuse = 3) can never be strictly less than any
    // Tnew, so this gate only makes the intent explicit.
    assign w_rs_used = (D_tuse_rs != TUSE_NONE);
    assign w_rt_used = (D_tuse_rt != TUSE_NONE);

    // Stall when the producer result is not forwardable before D needs it.
    // $0 is hard-wired, so it never creates a dependency.
    assign w_rs_hazard = w_rs_used && (D_rs != 5'd0) &&
                         (((D_rs == E_wa) && (D_tuse_rs < E_tnew)) ||
                          ((D_rs == M_wa) && (D_tuse_rs < M_tnew)));

    assign w_rt_hazard = w_rt_used && (D_rt != 5'd0) &&
                         (((D_rt == E_wa) && (D_tuse_rt < E_tnew)) ||
                          ((D_rt == M_wa) && (D_tuse_rt < M_tnew)));

    // The issuing mult/div counts as busy in its own E cycle
    assign w_md_stall  = D_is_md && (md_busy || E_md_start);

    // eret must read the EPC value that an older mtc0 is still writing
    assign w_epc_stall = D_is_eret && (E_mtc0_epc || M_mtc0_epc);

    // A flush overrides any stall: no hold and no bubble
    assign w_stall = (w_rs_hazard || w_rt_hazard || w_md_stall || w_epc_stall)
                     && !exc_req;

    assign D_REG_Wr  = ~w_stall;
    assign PC_Wr     = ~w_stall;
    assign E_REG_clr = w_stall;
    assign Req       = exc_req;

    pipe_stall_ctrl_md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .i_start  (E_md_start),
        .i_div    (E_md_div),
        .i_squash (exc_req),
        .o_busy   (md_busy)
    );

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl. A cycle-indexed
//                reference model (busy window = [start_cycle, start_cycle+N))
//                is compared against every output on each falling edge, and
//                directed scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div, D_is_eret;
    logic       E_mtc0_epc, M_mtc0_epc, exc_req;
    logic       Req, D_REG_Wr, PC_Wr, E_REG_clr, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .D_is_eret  (D_is_eret),
        .E_mtc0_epc (E_mtc0_epc),
        .M_mtc0_epc (M_mtc0_epc),
        .exc_req    (exc_req),
        .Req        (Req),
        .D_REG_Wr   (D_REG_Wr),
        .PC_Wr      (PC_Wr),
        .E_REG_clr  (E_REG_clr),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int cyc      = 0;
    int busy_end = 0;   // unit is busy while cyc < busy_end

    function automatic bit m_busy();
        return (cyc < busy_end);
    endfunction

    function automatic bit m_dep(input logic [4:0] r, input logic [1:0] tuse);
        bit d;
        d = 1'b0;
        if (r != 0) begin
            if (r == E_wa && int'(tuse) < int'(E_tnew)) d = 1'b1;
            if (r == M_wa && int'(tuse) < int'(M_tnew)) d = 1'b1;
        end
        return d;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = m_dep(D_rs, D_tuse_rs) | m_dep(D_rt, D_tuse_rt);
        if (D_is_md && (m_busy() || E_md_start)) s = 1'b1;
        if (D_is_eret && (E_mtc0_epc || M_mtc0_epc)) s = 1'b1;
        if (exc_req) s = 1'b0;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_end <= 0;
        end else if (E_md_start && !exc_req && !m_busy()) begin
            // busy for cycles cyc+1 .. cyc+N after this edge
            busy_end <= cyc + 1 + (E_md_div ? 10 : 5);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issuing a mult/div while the unit is busy must never happen
    always @(posedge clk) begin
        if (reset && E_md_start) chk("no_start_while_busy", int'(m_busy()), 0);
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_md_busy",   int'(md_busy),   int'(m_busy()));
        chk("model_Req",       int'(Req),       int'(exc_req));
        chk("model_D_REG_Wr",  int'(D_REG_Wr),  int'(!m_stall()));
        chk("model_PC_Wr",     int'(PC_Wr),     int'(!m_stall()));
        chk("model_E_REG_clr", int'(E_REG_clr), int'(m_stall()));
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        D_is_md = 0; E_md_start = 0; E_md_div = 0; D_is_eret = 0;
        E_mtc0_epc = 0; M_mtc0_epc = 0; exc_req = 0;
    endtask

    // Wait to just after the next falling edge (inputs settled, model updated)
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stall(input string name, input bit s);
        sample();
        chk({name, "_DWr"}, int'(D_REG_Wr),  int'(!s));
        chk({name, "_PCWr"}, int'(PC_Wr),    int'(!s));
        chk({name, "_Eclr"}, int'(E_REG_clr), int'(s));
    endtask

    task automatic md_run(input bit div, input int n);
        next_cycle();
        D_is_md = 1; E_md_start = 1; E_md_div = div;
        expect_stall("md_issue", 1'b1);
        next_cycle();               // edge t: start accepted
        E_md_start = 0;
        for (int i = 1; i <= n; i++) begin
            sample();
            chk("md_busy_window", int'(md_busy), 1);
            chk("md_hold_window", int'(D_REG_Wr), 0);
        end
        sample();
        chk("md_busy_release", int'(md_busy), 0);
        chk("md_adv_release",  int'(D_REG_Wr), 1);
        D_is_md = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        exc_req = 1;
        sample();
        chk("rst_md_busy", int'(md_busy), 0);
        chk("rst_DWr",     int'(D_REG_Wr), 1);
        chk("rst_PCWr",    int'(PC_Wr), 1);
        chk("rst_Eclr",    int'(E_REG_clr), 0);
        chk("rst_Req",     int'(Req), 1);
        exc_req = 0;
        sample();
        chk("rst_Req0",    int'(Req), 0);
        next_cycle();
        reset = 1;

        // load-use on rs via E
        next_cycle();
        D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 2;
        expect_stall("loaduse_rs", 1'b1);
        E_tnew = 0;
        expect_stall("loaduse_rs_ready", 1'b0);

        // rt via M
        idle_inputs();
        D_rt = 7; D_tuse_rt = 1; M_wa = 7; M_tnew = 2;
        expect_stall("rt_M", 1'b1);
        D_tuse_rt = 2;
        expect_stall("rt_M_ok", 1'b0);

        // $0 and unused operand
        idle_inputs();
        D_rs = 0; D_tuse_rs = 0; E_wa = 0; E_tnew = 2;
        expect_stall("zero_reg", 1'b0);
        D_rs = 5; D_tuse_rs = 3; E_wa = 5; E_tnew = 2;
        expect_stall("tuse_none", 1'b0);
        E_tnew = 3;
        expect_stall("tuse_none_t3", 1'b0);
        idle_inputs();

        // div / mult busy windows
        md_run(1'b1, 10);
        md_run(1'b0, 5);

        // squash: exception with coincident start
        next_cycle();
        exc_req = 1; E_md_start = 1; E_md_div = 1; D_is_md = 1;
        sample();
        chk("squash_Req",  int'(Req), 1);
        chk("squash_DWr",  int'(D_REG_Wr), 1);
        chk("squash_Eclr", int'(E_REG_clr), 0);
        next_cycle();
        E_md_start = 0; exc_req = 0;
        sample();
        chk("squash_busy", int'(md_busy), 0);
        chk("squash_noSt", int'(D_REG_Wr), 1);
        idle_inputs();
        D_rs = 9; D_tuse_rs = 0; E_wa = 9; E_tnew = 2; exc_req = 1;
        sample();
        chk("haz_exc_Eclr", int'(E_REG_clr), 0);
        chk("haz_exc_DWr",  int'(D_REG_Wr), 1);
        idle_inputs();

        // eret waits for EPC writes in E then M
        next_cycle();
        D_is_eret = 1; E_mtc0_epc = 1;
        expect_stall("eret_E", 1'b1);
        next_cycle();
        E_mtc0_epc = 0; M_mtc0_epc = 1;
        expect_stall("eret_M", 1'b1);
        next_cycle();
        M_mtc0_epc = 0;
        expect_stall("eret_go", 1'b0);
        idle_inputs();

        // exception during BUSY: countdown continues
        next_cycle();
        E_md_start = 1; E_md_div = 0;
        next_cycle();
        E_md_start = 0; exc_req = 1;
        sample();
        chk("exc_busy_cont", int'(md_busy), 1);
        exc_req = 0;
        repeat (6) next_cycle();
        sample();
        chk("exc_busy_done", int'(md_busy), 0);

        // async reset mid-divide (count at 6)
        next_cycle();
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        next_cycle();               // count = 10
        E_md_start = 0;
        repeat (4) next_cycle();    // count = 6
        sample();
        chk("pre_rst_busy", int'(md_busy), 1);
        #1;
        reset = 0;
        #1;
        chk("async_rst_busy", int'(md_busy), 0);
        chk("async_rst_DWr",  int'(D_REG_Wr), 1);
        next_cycle();
        reset = 1;
        sample();
        chk("post_rst_busy", int'(md_busy), 0);
        chk("post_rst_DWr",  int'(D_REG_Wr), 1);
        next_cycle();
        sample();
        chk("post_rst_busy2", int'(md_busy), 0);
        idle_inputs();

        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
